// File: rtl/serial_adder_nb.sv
// serial_adder_nb: multi-cycle adder/subtractor. It processes WIDTH-bit operands
// CHUNK bits per clock through one registered carry, with a start/busy/done handshake.
// The result is held between operations.
//
// Ports:
//   clk    in   clock; all state updates on the rising edge
//   rst    in   synchronous, active-high reset
//   start  in   operation request, sampled only while idle
//   sub    in   0 = A+B, 1 = A-B (latched with start)
//   A, B   in   WIDTH-bit operands (latched with start)
//   busy   out  high while chunks are being processed
//   done   out  one-cycle pulse when s/ovf have just been updated
//   s      out  WIDTH+1 result; s[WIDTH] = carry (add) or borrow (sub)
//   ovf    out  two's-complement overflow of the last result
module serial_adder_nb #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned CHUNK = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             sub,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   output logic             busy,
   output logic             done,
   output logic [WIDTH:0]   s,
   output logic             ovf
);

   localparam int unsigned N     = WIDTH / CHUNK;
   localparam int unsigned CNT_W = (N > 1) ? $clog2(N) : 1;
   localparam int unsigned CS_W  = CHUNK + 1;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_RUN  = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   // Reject parameter sets that cannot be split into whole chunks.
   if (WIDTH < 2 || CHUNK < 1 || CHUNK > WIDTH || (WIDTH % CHUNK) != 0) begin : g_bad_params
      $error("serial_adder_nb: WIDTH must be >= 2 and a multiple of CHUNK");
   end

   logic [1:0]       state_q, state_d;
   logic [WIDTH-1:0] opa_q, opa_d;
   logic [WIDTH-1:0] opb_q, opb_d;
   logic [WIDTH-1:0] acc_q, acc_d;
   logic             carry_q, carry_d;
   logic             sub_q, sub_d;
   logic             amsb_q, amsb_d;
   logic             bmsb_q, bmsb_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic [WIDTH:0]   s_q, s_d;
   logic             ovf_q, ovf_d;

   logic [CHUNK:0]   chunk_sum_c;
   logic [WIDTH-1:0] acc_nxt_c;
   logic             last_c;
   logic             cout_c;

   // One CHUNK-wide add of the current low operand bits plus the running carry.
   assign chunk_sum_c = {1'b0, opa_q[CHUNK-1:0]} + {1'b0, opb_q[CHUNK-1:0]}
                        + CS_W'(carry_q);
   assign cout_c      = chunk_sum_c[CHUNK];

   // Sum chunks enter at the top and move down, so the first chunk ends at the LSB.
   assign acc_nxt_c   = (acc_q >> CHUNK)
                        | (WIDTH'(chunk_sum_c[CHUNK-1:0]) << (WIDTH - CHUNK));

   assign last_c      = (cnt_q == CNT_W'(N - 1));

   // Next-state and datapath update.
   always_comb begin
      state_d = state_q;
      opa_d   = opa_q;
      opb_d   = opb_q;
      acc_d   = acc_q;
      carry_d = carry_q;
      sub_d   = sub_q;
      amsb_d  = amsb_q;
      bmsb_d  = bmsb_q;
      cnt_d   = cnt_q;
      busy_d  = 1'b0;
      done_d  = 1'b0;
      s_d     = s_q;
      ovf_d   = ovf_q;

      case (state_q)
         ST_IDLE: begin
            if (start) begin
               // Subtraction is A + ~B + 1; the +1 enters as the initial carry.
               opa_d   = A;
               opb_d   = sub ? ~B : B;
               carry_d = sub;
               sub_d   = sub;
               amsb_d  = A[WIDTH-1];
               bmsb_d  = sub ? ~B[WIDTH-1] : B[WIDTH-1];
               acc_d   = '0;
               cnt_d   = '0;
               busy_d  = 1'b1;
               state_d = ST_RUN;
            end
         end

         ST_RUN: begin
            opa_d   = opa_q >> CHUNK;
            opb_d   = opb_q >> CHUNK;
            carry_d = cout_c;
            acc_d   = acc_nxt_c;
            cnt_d   = cnt_q + CNT_W'(1);
            busy_d  = 1'b1;
            if (last_c) begin
               // A final carry of 0 during subtraction means a borrow occurred.
               s_d     = {(sub_q ? ~cout_c : cout_c), acc_nxt_c};
               ovf_d   = (amsb_q == bmsb_q) && (acc_nxt_c[WIDTH-1] != amsb_q);
               cnt_d   = '0;
               busy_d  = 1'b0;
               done_d  = 1'b1;
               state_d = ST_DONE;
            end
         end

         ST_DONE: begin
            state_d = ST_IDLE;
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State and output registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         opa_q   <= '0;
         opb_q   <= '0;
         acc_q   <= '0;
         carry_q <= 1'b0;
         sub_q   <= 1'b0;
         amsb_q  <= 1'b0;
         bmsb_q  <= 1'b0;
         cnt_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         s_q     <= '0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         opa_q   <= opa_d;
         opb_q   <= opb_d;
         acc_q   <= acc_d;
         carry_q <= carry_d;
         sub_q   <= sub_d;
         amsb_q  <= amsb_d;
         bmsb_q  <= bmsb_d;
         cnt_q   <= cnt_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         s_q     <= s_d;
         ovf_q   <= ovf_d;
      end
   end

   assign busy = busy_q;
   assign done = done_q;
   assign s    = s_q;
   assign ovf  = ovf_q;

endmodule

// File: tb/tb_serial_adder_nb.sv
// tb_serial_adder_nb: directed bench for serial_adder_nb. It uses an 8-bit/2-bit-chunk
// instance and a 2-bit/1-bit-chunk instance. Expected results are queued when an
// operation starts and compared when done pulses.
module tb_serial_adder_nb;

   logic clk = 1'b0;
   logic rst;

   logic       start8, sub8, busy8, done8, ovf8;
   logic [7:0] a8, b8;
   logic [8:0] s8;

   logic       start2, sub2, busy2, done2, ovf2;
   logic [1:0] a2, b2;
   logic [2:0] s2;

   int checks = 0;
   int errors = 0;

   logic [31:0] q8[$];
   logic [31:0] q2[$];

   always #5 clk = ~clk;

   serial_adder_nb #(.WIDTH(8), .CHUNK(2)) u_dut8 (
      .clk(clk), .rst(rst), .start(start8), .sub(sub8), .A(a8), .B(b8),
      .busy(busy8), .done(done8), .s(s8), .ovf(ovf8)
   );

   serial_adder_nb #(.WIDTH(2), .CHUNK(1)) u_dut2 (
      .clk(clk), .rst(rst), .start(start2), .sub(sub2), .A(a2), .B(b2),
      .busy(busy2), .done(done2), .s(s2), .ovf(ovf2)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Reference result packed as {ovf, s[w:0]} from plain integer arithmetic.
   function automatic logic [31:0] model(input int w, input int a, input int b, input bit sb);
      int m, h, r, sa, sbv, sr;
      bit top, ov;
      logic [31:0] res;
      m   = 1 << w;
      h   = 1 << (w - 1);
      r   = sb ? a - b : a + b;
      top = sb ? (a < b) : (r >= m);
      sa  = (a >= h) ? a - m : a;
      sbv = (b >= h) ? b - m : b;
      sr  = sb ? sa - sbv : sa + sbv;
      ov  = (sr > h - 1) || (sr < -h);
      res = 32'(((r % m) + m) % m) | (32'(top) << w) | (32'(ov) << (w + 1));
      return res;
   endfunction

   task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic sb,
                       input bit disturb, input string tag);
      int k, busy_cnt;
      bit seen;
      logic [31:0] exp;
      start8 = 1'b1; a8 = a; b8 = b; sub8 = sb;
      q8.push_back(model(8, int'(a), int'(b), sb));
      @(posedge clk); @(negedge clk);
      start8 = 1'b0;
      a8 = 8'($urandom); b8 = 8'($urandom); sub8 = 1'($urandom);
      busy_cnt = 0; seen = 1'b0; k = 0;
      while (!seen && k < 40) begin
         if (busy8) busy_cnt++;
         if (disturb && k == 1) begin
            start8 = 1'b1; a8 = 8'h3C; b8 = 8'hA5; sub8 = ~sb;
         end
         if (disturb && k == 2) start8 = 1'b0;
         @(posedge clk); @(negedge clk);
         k++;
         if (done8) seen = 1'b1;
      end
      check({tag, " done_seen"}, 32'(seen), 32'd1);
      check({tag, " latency"}, 32'(k), 32'd4);
      check({tag, " busy_cycles"}, 32'(busy_cnt), 32'd4);
      check({tag, " busy_at_done"}, 32'(busy8), 32'd0);
      exp = (q8.size() > 0) ? q8.pop_front() : 32'hDEAD;
      check({tag, " s"}, 32'(s8), 32'(exp[8:0]));
      check({tag, " ovf"}, 32'(ovf8), 32'(exp[9]));
      @(posedge clk); @(negedge clk);
      check({tag, " done_single"}, 32'(done8), 32'd0);
      check({tag, " s_hold"}, 32'(s8), 32'(exp[8:0]));
   endtask

   task automatic run2(input logic [1:0] a, input logic [1:0] b, input string tag);
      int k;
      bit seen;
      logic [31:0] exp;
      start2 = 1'b1; a2 = a; b2 = b; sub2 = 1'b0;
      q2.push_back(model(2, int'(a), int'(b), 1'b0));
      @(posedge clk); @(negedge clk);
      start2 = 1'b0; a2 = 2'($urandom); b2 = 2'($urandom);
      seen = 1'b0; k = 0;
      while (!seen && k < 20) begin
         @(posedge clk); @(negedge clk);
         k++;
         if (done2) seen = 1'b1;
      end
      check({tag, " latency"}, 32'(k), 32'd2);
      exp = (q2.size() > 0) ? q2.pop_front() : 32'hDEAD;
      check({tag, " s"}, 32'(s2), 32'({1'b0, a} + {1'b0, b}));
      check({tag, " s_model"}, 32'(s2), 32'(exp[2:0]));
      @(posedge clk); @(negedge clk);
   endtask

   initial begin
      int dones;
      rst = 1'b1;
      start8 = 1'b0; sub8 = 1'b0; a8 = '0; b8 = '0;
      start2 = 1'b0; sub2 = 1'b0; a2 = '0; b2 = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("reset busy8", 32'(busy8), 32'd0);
      check("reset done8", 32'(done8), 32'd0);
      check("reset s8", 32'(s8), 32'd0);
      check("reset ovf8", 32'(ovf8), 32'd0);
      check("reset s2", 32'(s2), 32'd0);
      rst = 1'b0;
      @(negedge clk);

      for (int a = 0; a < 4; a++) begin
         for (int b = 0; b < 4; b++) begin
            run2(2'(a), 2'(b), "t1_w2_add");
         end
      end

      run8(8'hFF, 8'h01, 1'b0, 1'b0, "t2_add_ff_01");
      check("t2 s literal", 32'(s8), 32'h100);
      run8(8'h05, 8'h07, 1'b1, 1'b0, "t3_sub_05_07");
      check("t3 s literal", 32'(s8), 32'h1FE);
      run8(8'h07, 8'h05, 1'b1, 1'b0, "t3_sub_07_05");
      check("t3b s literal", 32'(s8), 32'h002);
      run8(8'h7F, 8'h01, 1'b0, 1'b0, "t4_add_ovf");
      check("t4 ovf literal", 32'(ovf8), 32'd1);
      run8(8'h80, 8'h01, 1'b1, 1'b0, "t4_sub_ovf");
      check("t4b s literal", 32'(s8), 32'h07F);
      run8(8'h5A, 8'hC3, 1'b0, 1'b1, "t5_restart_ignored");
      run8(8'h00, 8'h00, 1'b1, 1'b0, "sub_zero");
      for (int i = 0; i < 6; i++) begin
         run8(8'($urandom), 8'($urandom), 1'($urandom), 1'b0, "rand");
      end

      // Abort mid-RUN: no done may follow, and the result must clear.
      run8(8'h12, 8'h34, 1'b0, 1'b0, "pre_reset");
      start8 = 1'b1; a8 = 8'hAA; b8 = 8'h55; sub8 = 1'b0;
      @(posedge clk); @(negedge clk);
      start8 = 1'b0;
      @(posedge clk); @(posedge clk); @(negedge clk);
      rst = 1'b1;
      @(posedge clk); @(negedge clk);
      check("t6 busy", 32'(busy8), 32'd0);
      check("t6 done", 32'(done8), 32'd0);
      check("t6 s", 32'(s8), 32'd0);
      check("t6 ovf", 32'(ovf8), 32'd0);
      rst = 1'b0;
      dones = 0;
      for (int i = 0; i < 10; i++) begin
         @(posedge clk); @(negedge clk);
         if (done8) dones++;
      end
      check("t6 no_done", 32'(dones), 32'd0);
      run8(8'hC8, 8'h64, 1'b0, 1'b0, "t6_after_reset");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
